// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display controller.
// Glyphs are active low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry 0 is the rightmost element: glyphs for 0..9 then A,b,C,d,E,F.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg7_drive_t;

  localparam seg7_drive_t DRIVE_OFF = '{seg: SEG_BLANK, dp: 1'b1};

  function automatic logic [6:0] seg7_glyph(input logic [3:0] code, input logic hex_mode);
    if (hex_mode || (code < 4'd10)) begin
      return GLYPH_TABLE[code];
    end else begin
      return SEG_BLANK;
    end
  endfunction

  function automatic int unsigned seg7_ticks(input int unsigned clock_hz, input int unsigned ms);
    return (clock_hz / 1000) * ms;
  endfunction

  function automatic int unsigned seg7_cnt_w(input int unsigned count);
    if (count <= 1) begin
      return 1;
    end else begin
      return $clog2(count);
    end
  endfunction

endpackage

// File: rtl/seg7_tick_div.sv
// Terminal-count divider: counts 0..COUNT-1 while enabled, flags the terminal
// count, and clears synchronously on clr_i (clear wins over counting).
module seg7_tick_div
  import seg7_pkg::*;
#(
  parameter int unsigned COUNT = 2,
  parameter int unsigned CNT_W = seg7_cnt_w(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // next count: clear, wrap at terminal count, or hold when disabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_mux_ndigit.sv
// N-digit multiplexed common-anode 7-segment controller with PWM dimming,
// hex glyphs, leading-zero suppression, per-digit blink and ghost blanking.
module seg7_mux_ndigit
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned CLOCK_FREQ_HZ = 100_000_000,
  parameter int unsigned DIGIT_HZ      = 1000,
  parameter int unsigned DIM_BITS      = 4,
  parameter int unsigned GHOST_CYCLES  = 16,
  parameter int unsigned UPDATE_MS     = 200,
  parameter int unsigned BLINK_MS      = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    dim_up_pls_i,
  input  logic                    dim_dwn_pls_i,
  output logic [DIM_BITS-1:0]     dim_val_o,
  input  logic [4*NUM_DIGITS-1:0] x_i,
  input  logic [NUM_DIGITS-1:0]   x_dp_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic                    hex_mode_i,
  input  logic                    lz_suppress_i,
  input  logic                    load_now_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int unsigned SLOT_CYCLES   = CLOCK_FREQ_HZ / DIGIT_HZ;
  localparam int unsigned UPDATE_CYCLES = seg7_ticks(CLOCK_FREQ_HZ, UPDATE_MS);
  localparam int unsigned BLINK_CYCLES  = seg7_ticks(CLOCK_FREQ_HZ, BLINK_MS);
  localparam int unsigned SLOT_W        = seg7_cnt_w(SLOT_CYCLES);
  localparam int unsigned UPD_W         = seg7_cnt_w(UPDATE_CYCLES);
  localparam int unsigned BLK_W         = seg7_cnt_w(BLINK_CYCLES);
  localparam int unsigned DIG_W         = seg7_cnt_w(NUM_DIGITS);

  localparam logic [SLOT_W-1:0]     GHOST_END = SLOT_W'(GHOST_CYCLES);
  localparam logic [DIM_BITS-1:0]   DIM_RESET = DIM_BITS'(1 << (DIM_BITS - 1));
  localparam logic [DIM_BITS-1:0]   DIM_MAX   = '1;
  localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

  if ((NUM_DIGITS < 2) || (NUM_DIGITS > 8)) begin : g_chk_digits
    $error("seg7_mux_ndigit: NUM_DIGITS must be within 2..8");
  end
  if (SLOT_CYCLES <= (GHOST_CYCLES + (1 << DIM_BITS))) begin : g_chk_slot
    $error("seg7_mux_ndigit: SLOT_CYCLES must exceed GHOST_CYCLES + 2**DIM_BITS");
  end

  logic [SLOT_W-1:0]     slot_cnt_s;
  logic                  slot_tick_s;
  logic [UPD_W-1:0]      upd_cnt_s;
  logic                  upd_tick_s;
  logic [BLK_W-1:0]      blink_cnt_s;
  logic                  blink_tick_s;
  logic                  unused_cnt_s;

  logic [DIG_W-1:0]        dig_q, dig_d;
  logic [DIM_BITS-1:0]     pwm_q, pwm_d;
  logic [DIM_BITS-1:0]     dim_q, dim_d;
  logic                    blink_ph_q, blink_ph_d;
  logic [4*NUM_DIGITS-1:0] disp_x_q, disp_x_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blink_q, disp_blink_d;
  logic                    latch_s;

  logic [NUM_DIGITS-1:0] supp_s;
  logic                  zero_run;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s;
  logic                  lit_s;

  seg7_drive_t           drv_q, drv_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  seg7_tick_div #(.COUNT(SLOT_CYCLES)) u_slot_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .clr_i  (1'b0),
    .cnt_o  (slot_cnt_s),
    .tick_o (slot_tick_s)
  );

  // load_now restarts the update interval as well as forcing the latch
  seg7_tick_div #(.COUNT(UPDATE_CYCLES)) u_update_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .clr_i  (load_now_i),
    .cnt_o  (upd_cnt_s),
    .tick_o (upd_tick_s)
  );

  seg7_tick_div #(.COUNT(BLINK_CYCLES)) u_blink_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .clr_i  (1'b0),
    .cnt_o  (blink_cnt_s),
    .tick_o (blink_tick_s)
  );

  assign unused_cnt_s = ^{upd_cnt_s, blink_cnt_s};
  assign latch_s      = load_now_i || upd_tick_s;

  // scan, dimming, blink and latch next-state
  always_comb begin
    dig_d        = dig_q;
    pwm_d        = pwm_q;
    dim_d        = dim_q;
    blink_ph_d   = blink_ph_q;
    disp_x_d     = disp_x_q;
    disp_dp_d    = disp_dp_q;
    disp_blink_d = disp_blink_q;

    if (slot_tick_s) begin
      if (dig_q == '0) begin
        dig_d = DIG_LAST;
      end else begin
        dig_d = dig_q - 1'b1;
      end
    end else begin
      dig_d = dig_q;
    end

    if (en_i) begin
      pwm_d = pwm_q + 1'b1;
    end else begin
      pwm_d = pwm_q;
    end

    // simultaneous up and down pulses cancel
    if (dim_up_pls_i && !dim_dwn_pls_i) begin
      if (dim_q != DIM_MAX) begin
        dim_d = dim_q + 1'b1;
      end else begin
        dim_d = dim_q;
      end
    end else if (dim_dwn_pls_i && !dim_up_pls_i) begin
      if (dim_q != '0) begin
        dim_d = dim_q - 1'b1;
      end else begin
        dim_d = dim_q;
      end
    end else begin
      dim_d = dim_q;
    end

    if (blink_tick_s) begin
      blink_ph_d = !blink_ph_q;
    end else begin
      blink_ph_d = blink_ph_q;
    end

    if (latch_s) begin
      disp_x_d     = x_i;
      disp_dp_d    = x_dp_i;
      disp_blink_d = blink_i;
    end else begin
      disp_x_d     = disp_x_q;
      disp_dp_d    = disp_dp_q;
      disp_blink_d = disp_blink_q;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q        <= DIG_LAST;
      pwm_q        <= '0;
      dim_q        <= DIM_RESET;
      blink_ph_q   <= 1'b0;
      disp_x_q     <= '0;
      disp_dp_q    <= '0;
      disp_blink_q <= '0;
    end else begin
      dig_q        <= dig_d;
      pwm_q        <= pwm_d;
      dim_q        <= dim_d;
      blink_ph_q   <= blink_ph_d;
      disp_x_q     <= disp_x_d;
      disp_dp_q    <= disp_dp_d;
      disp_blink_q <= disp_blink_d;
    end
  end

  // a digit is a leading zero while it and everything left of it is a bare zero
  always_comb begin
    zero_run = 1'b1;
    supp_s   = '0;
    for (int j = int'(NUM_DIGITS) - 1; j >= 0; j--) begin
      zero_run  = zero_run && (disp_x_q[4*j +: 4] == 4'd0) && !disp_dp_q[j];
      supp_s[j] = lz_suppress_i && zero_run && (j != 0);
    end
  end

  // current digit selection and lit decision
  always_comb begin
    cur_nib_s = disp_x_q[{dig_q, 2'b00} +: 4];
    cur_dp_s  = disp_dp_q[dig_q];
    lit_s     = (pwm_q < dim_q)
             && !(disp_blink_q[dig_q] && blink_ph_q)
             && !supp_s[dig_q];
  end

  // output drive next-state
  always_comb begin
    an_d  = '1;
    drv_d = DRIVE_OFF;
    if (!en_i) begin
      an_d  = '1;
      drv_d = DRIVE_OFF;
    end else if (slot_cnt_s < GHOST_END) begin
      an_d  = '1;
      drv_d = DRIVE_OFF;
    end else begin
      an_d = ~(AN_ONE << dig_q);
      if (lit_s) begin
        drv_d.seg = seg7_glyph(cur_nib_s, hex_mode_i);
        drv_d.dp  = !cur_dp_s;
      end else begin
        drv_d = DRIVE_OFF;
      end
    end
  end

  // registered display pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      drv_q <= DRIVE_OFF;
    end else begin
      an_q  <= an_d;
      drv_q <= drv_d;
    end
  end

  assign an_o      = an_q;
  assign seg_o     = drv_q.seg;
  assign dp_o      = drv_q.dp;
  assign dim_val_o = dim_q;

endmodule

// File: tb/tb_seg7_mux_ndigit.sv
// Self-checking bench: a cycle-count based reference model checked every clock,
// plus directed scenarios with hand-computed expectations.
module tb_seg7_mux_ndigit;

  localparam int N     = 4;
  localparam int SLOT  = 100;
  localparam int UPD   = 1000;
  localparam int BLK   = 2000;
  localparam int GHOST = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, up = 1'b0, dwn = 1'b0, hexm = 1'b0, lz = 1'b0, ld = 1'b0;
  logic [15:0] x = 16'h0000;
  logic [3:0]  xdp = 4'b0000, blk = 4'b0000;
  logic [3:0]  dim_val;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  logic [6:0] glyph_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_mux_ndigit #(
    .NUM_DIGITS(4), .CLOCK_FREQ_HZ(1_000_000), .DIGIT_HZ(10_000), .DIM_BITS(4),
    .GHOST_CYCLES(16), .UPDATE_MS(1), .BLINK_MS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .dim_up_pls_i(up), .dim_dwn_pls_i(dwn),
    .dim_val_o(dim_val), .x_i(x), .x_dp_i(xdp), .blink_i(blk), .hex_mode_i(hexm),
    .lz_suppress_i(lz), .load_now_i(ld), .seg_o(seg), .dp_o(dp), .an_o(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model state: enabled-cycle count drives every timebase
  int          m_t, m_upd, m_dim;
  logic [15:0] m_x;
  logic [3:0]  m_dp, m_bl;

  function automatic logic [6:0] glyph(input logic [3:0] c, input logic h);
    if ((c < 4'd10) || h) return glyph_ref[c];
    return 7'h7F;
  endfunction

  function automatic bit suppressed(input int d);
    if (!lz || d == 0) return 1'b0;
    for (int j = d; j < N; j++) begin
      if (m_x[4*j +: 4] != 4'd0 || m_dp[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model_cmp
    int slot, d, pwm, ph;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    bit         lit;
    #1;
    if (!rst_n) begin
      m_t = 0; m_upd = 0; m_dim = 8; m_x = 16'h0000; m_dp = 4'b0000; m_bl = 4'b0000;
    end else begin
      slot = m_t % SLOT;
      d    = N - 1 - ((m_t / SLOT) % N);
      pwm  = m_t % 16;
      ph   = (m_t / BLK) % 2;
      lit  = (pwm < m_dim) && !(m_bl[d] && ph == 1) && !suppressed(d);
      e_an = 4'b0001 << d;
      e_an = ~e_an;
      e_seg = lit ? glyph(m_x[4*d +: 4], hexm) : 7'h7F;
      e_dp  = lit ? !m_dp[d] : 1'b1;
      if (!en) begin
        chk("off_an", an, 4'hF);
        chk("off_seg", seg, 7'h7F);
        chk("off_dp", dp, 1'b1);
      end else if (slot < GHOST) begin
        chk("ghost_an", an, 4'hF);
      end else begin
        chk("scan_an", an, e_an);
        chk("scan_seg", seg, e_seg);
        chk("scan_dp", dp, e_dp);
      end
      if (en) m_t++;
      if (up && !dwn && m_dim < 15) m_dim++;
      else if (dwn && !up && m_dim > 0) m_dim--;
      if (ld) begin
        m_x = x; m_dp = xdp; m_bl = blk; m_upd = 0;
      end else if (en) begin
        if (m_upd == UPD - 1) begin
          m_x = x; m_dp = xdp; m_bl = blk; m_upd = 0;
        end else begin
          m_upd++;
        end
      end
      chk("dim_val", dim_val, m_dim);
    end
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    ncyc += n;
  endtask

  task automatic adv_to(input int t);
    adv(t - ncyc);
  endtask

  task automatic load();
    ld = 1'b1;
    adv(1);
    ld = 1'b0;
    adv(2);
  endtask

  logic [N-1:0] c_lit;
  logic [6:0]   c_seg [N];
  logic         c_dp [N];

  task automatic collect(input int n);
    logic [3:0] sel;
    c_lit = '0;
    for (int i = 0; i < N; i++) begin c_seg[i] = 7'h7F; c_dp[i] = 1'b1; end
    repeat (n) begin
      adv(1);
      for (int i = 0; i < N; i++) begin
        sel = 4'b0001 << i;
        if (an == ~sel && (seg != 7'h7F || dp == 1'b0)) begin
          c_lit[i] = 1'b1; c_seg[i] = seg; c_dp[i] = dp;
        end
      end
    end
  endtask

  initial begin : stim
    int off, cnt, l0p0, l0p1, l3p1;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_dim", dim_val, 4'd8);

    // reset and first auto latch at edge 1000
    x = 16'h1234; en = 1'b1; rst_n = 1'b1; ncyc = 0;
    adv_to(129);  chk("prelatch_an", an, 4'b1011); chk("prelatch_seg", seg, 7'h40);
    adv_to(1025); chk("d1_an", an, 4'b1101);       chk("d1_seg", seg, 7'h30);
    adv_to(1121); chk("d0_an", an, 4'b1110);       chk("d0_seg", seg, 7'h19);
    adv_to(1201); chk("ghost_lit_an", an, 4'hF);
    adv_to(1233); chk("d3_an", an, 4'b0111);       chk("d3_seg", seg, 7'h79);

    // dimming
    repeat (20) begin dwn = 1'b1; adv(1); dwn = 1'b0; adv(1); end
    chk("dim_floor", dim_val, 4'd0);
    collect(200);
    chk("dark_at_0", c_lit, 4'b0000);
    repeat (20) begin up = 1'b1; adv(1); up = 1'b0; adv(1); end
    chk("dim_ceil", dim_val, 4'd15);
    off = (131 - (ncyc % 100)) % 100;
    if (off < 1) off += 100;
    adv_to(ncyc + off - 1);
    cnt = 0;
    repeat (16) begin adv(1); if (seg != 7'h7F) cnt++; end
    chk("lit_15_of_16", cnt, 15);
    up = 1'b1; dwn = 1'b1; adv(1); up = 1'b0; dwn = 1'b0; adv(1);
    chk("dim_both", dim_val, 4'd15);
    dwn = 1'b1; adv(1); dwn = 1'b0; adv(1);
    chk("dim_dec", dim_val, 4'd14);

    // hex glyphs
    x = 16'hABCD; hexm = 1'b0; load();
    collect(400);
    chk("hex_off_blank", c_lit, 4'b0000);
    hexm = 1'b1;
    collect(400);
    chk("hex_A", c_seg[3], 7'h08);
    chk("hex_b", c_seg[2], 7'h03);
    chk("hex_C", c_seg[1], 7'h46);
    chk("hex_d", c_seg[0], 7'h21);

    // leading-zero suppression
    hexm = 1'b0; lz = 1'b1; x = 16'h0045; load();
    collect(400);
    chk("lz45_lit", c_lit, 4'b0011);
    chk("lz45_d1", c_seg[1], 7'h19);
    chk("lz45_d0", c_seg[0], 7'h12);
    x = 16'h0000; load();
    collect(400);
    chk("lz0_lit", c_lit, 4'b0001);
    chk("lz0_d0", c_seg[0], 7'h40);
    xdp = 4'b0100; load();
    collect(400);
    chk("lzdp_lit", c_lit, 4'b0111);
    chk("lzdp_seg", c_seg[2], 7'h40);
    chk("lzdp_dp", c_dp[2], 1'b0);

    // blink on digit 0 only
    lz = 1'b0; xdp = 4'b0000; x = 16'h1234; blk = 4'b0001; load();
    l0p0 = 0; l0p1 = 0; l3p1 = 0;
    repeat (4000) begin
      adv(1);
      if (an == 4'b1110 && seg != 7'h7F) begin
        if (((ncyc - 1) / BLK) % 2 == 1) l0p1++; else l0p0++;
      end
      if (an == 4'b0111 && seg != 7'h7F && ((ncyc - 1) / BLK) % 2 == 1) l3p1++;
    end
    chk("blink_off_phase", l0p1, 0);
    chk("blink_on_phase", l0p0 > 0, 1);
    chk("blink_other_lit", l3p1 > 0, 1);

    // load_now restarts the update interval
    x = 16'h5678; adv(300);
    ld = 1'b1; adv(1); ld = 1'b0; x = 16'h9999; adv(1);
    collect(985);
    chk("load_kept", c_seg[3], 7'h12);
    adv(15);
    collect(400);
    chk("auto_after_load", c_seg[3], 7'h10);

    // enable off and on
    en = 1'b0; adv(1);
    chk("en_off_an", an, 4'hF);
    adv(50);
    en = 1'b1; adv(300);

    // asynchronous reset mid-slot
    @(negedge clk); #3; rst_n = 1'b0; #1;
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_dp", dp, 1'b1);
    chk("arst_dim", dim_val, 4'd8);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; ncyc = 0;
    adv_to(129); chk("rerun_an", an, 4'b1011); chk("rerun_seg", seg, 7'h40);
    adv(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_mux_ndigit.md
# seg7_mux_ndigit

Parametrised N-digit multiplexed 7-segment display controller, the successor to the fixed 4-digit multimeter display driver. It sits between the BCD/hex formatting logic and the board's common-anode display pins. It adds the following over the 4-digit driver:
- configurable digit count and dimming resolution
- hex glyphs
- leading-zero suppression
- per-digit blink
- forced immediate load
- all-anode-off ghost blanking

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits/anodes (2..8)
- CLOCK_FREQ_HZ, 100_000_000: clk frequency
- DIGIT_HZ, 1000: slot rate; SLOT_CYCLES = CLOCK_FREQ_HZ/DIGIT_HZ
- DIM_BITS, 4: PWM/dimming resolution
- GHOST_CYCLES, 16: blank cycles at the start of each slot
- UPDATE_MS, 200: display-latch interval
- BLINK_MS, 500: blink half-period

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  enable; 0 = display dark, all counters frozen
- dim_up_pls  in  1  one-cycle pulse, brightness +1
- dim_dwn_pls  in  1  one-cycle pulse, brightness −1
- dim_val  out  DIM_BITS  current brightness
- x  in  4*NUM_DIGITS  digit codes, nibble i = x[4i+:4], digit NUM_DIGITS-1 leftmost
- x_dp  in  NUM_DIGITS  decimal point per digit, active high
- blink  in  NUM_DIGITS  per-digit blink enable
- hex_mode  in  1  1 = codes 10..15 show A,b,C,d,E,F; 0 = blank
- lz_suppress  in  1  leading-zero suppression enable
- load_now  in  1  pulse, latch x/x_dp/blink immediately
- seg  out  7  segments {g..a}, active low
- dp  out  1  decimal point, active low
- an  out  NUM_DIGITS  anodes, active low

## Operation
- **Brightness**
  - dim_val resets to 2^(DIM_BITS-1).
  - dim_up_pls increments dim_val, saturating at 2^DIM_BITS−1.
  - dim_dwn_pls decrements dim_val, saturating at 0.
  - Both pulses in the same cycle: no change.
  - Brightness pulses are honoured even when en=0.
- **Latch**
  - display_x, display_dp and display_blink reset to 0.
  - While en=1, update_cnt counts to UPDATE_CYCLES−1 = CLOCK_FREQ_HZ/1000*UPDATE_MS−1, then latches the inputs and wraps to 0.
  - load_now latches the inputs on the next edge and clears update_cnt. load_now wins over the terminal count.
  - load_now is honoured even when en=0.
- **Scan**
  - slot_cnt counts 0..SLOT_CYCLES−1.
  - At wrap, digit index d moves NUM_DIGITS−1 → … → 0 → NUM_DIGITS−1.
- **Digit d lit condition**: all of the following must hold.
  - slot_cnt ≥ GHOST_CYCLES.
  - pwm_cnt < dim_val. pwm_cnt is a free-running DIM_BITS counter, so dim_val=0 means dark.
  - The digit is not in a blink-off phase: display_blink[d]=0 or blink_ph=0.
  - The digit is not a suppressed leading zero.
- **Leading-zero suppression**: digit d>0 is suppressed when lz_suppress=1 and every nibble j≥d is 0 and every display_dp[j] with j≥d is 0. Digit 0 is never suppressed.
- **Blink**: blink_ph toggles every BLINK_MS (while en=1) and resets to 0.
- **Lit digit outputs**
  - an = ~(1<<d)
  - seg = glyph(nibble d, hex_mode)
  - dp = ~display_dp[d]
- **Not lit**
  - During the ghost window: an all 1s.
  - Otherwise: an = ~(1<<d), seg=7'h7F, dp=1.
- **en=0**: an all 1s, seg=7'h7F, dp=1. Counters hold their values.

## Timing
- seg, dp and an are registered, with 1-cycle latency from the internal state.
- Reset values: seg=7'h7F, dp=1, an all 1s, dim_val=2^(DIM_BITS−1).
- Latched data is visible on the outputs from the second clock after the latch edge.
- Reset asserted mid-scan: all outputs and counters return to reset values immediately (asynchronous). Scan restarts at d=NUM_DIGITS−1, slot_cnt=0.
- Elaboration-time assertions:
  - SLOT_CYCLES > GHOST_CYCLES + 2^DIM_BITS.
  - NUM_DIGITS within 2..8.

## Structure
- Package seg7_pkg holds:
  - SEG_BLANK=7'h7F
  - the 16-entry active-low glyph table for 0..F
  - the function seg7_glyph(code, hex_mode)
  - the tick-count helper function
- Sub-module seg7_tick_div provides a parametrised terminal-count divider with enable and sync clear. It is instantiated three times: slot, update and blink.

## Test plan
Sim parameters: CLOCK_FREQ_HZ=1_000_000, DIGIT_HZ=10_000 (SLOT=100), UPDATE_MS=1, BLINK_MS=2.
- **Reset and latch**: reset, x=16'h1234, en=1 → an cycles 0111,1011,1101,1110 with 100-cycle slots after the first latch at cycle 1000. seg=1→F9, 2→A4, 3→B0, 4→99. an all 1s for 16 cycles per slot.
- **Dimming**:
  - 20 dim_dwn_pls pulses → dim_val stays at 0 (no wrap), display dark.
  - 20 dim_up_pls pulses → dim_val saturates at 15; seg lit 15 of every 16 post-ghost cycles.
  - Simultaneous up/down pulses → no change.
- **Hex mode**: x=16'hABCD, hex_mode=0 → all digits blank. hex_mode=1 → 88,83,C6,A1.
- **Leading-zero suppression**:
  - x=16'h0045, lz_suppress=1 → digits 3,2 blank; 4,5 shown.
  - x=16'h0000 → only digit 0 shows "0".
  - x_dp=4'b0100 → digit 2 shown as "0.".
- **Blink and load_now**:
  - blink=4'b0001 → digit 0 dark in alternate 2000-cycle phases while the others stay lit.
  - load_now mid-interval → new x on the outputs 2 cycles later, and update_cnt restarts.
- **Enable and reset mid-scan**:
  - en=0 → an all 1s next cycle; on re-enable the scan resumes from the frozen d.
  - rst_n pulse mid-slot → immediate reset values.
